// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, datapath widths and the MEM/WB payload.
package pipeline_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned CTR_W           = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  readdata;
        logic [XLEN-1:0]  alu_result;
        logic [REG_W-1:0] rd;
        logic             memtoreg;
        logic             regwrite;
    } memwb_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the MEM stage; flags the last permitted BUSY cycle.
module mem_timeout_ctr
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CTR_W'(1);
        end
    end

    assign o_tc_c = (r_count == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls upstream
// until completion or timeout, and produces the MEM/WB register.
module mem_access
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic [XLEN-1:0]  writedata_in,
    input  logic [REG_W-1:0] rd_in,
    input  logic             memtoreg_in,
    input  logic             memwrite_in,
    input  logic             regwrite_in,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic             stall,
    output logic [XLEN-1:0]  readdata_out,
    output logic [XLEN-1:0]  alu_result_out,
    output logic [REG_W-1:0] rd_out,
    output logic             memtoreg_out,
    output logic             regwrite_out,
    output logic             misalign_out,
    output logic             bus_err_out
);

    state_e           r_state,    w_state_nx;
    memwb_t           r_wb,       w_wb_nx;
    logic             r_req,      w_req_nx;
    logic             r_we,       w_we_nx;
    logic [XLEN-1:0]  r_addr,     w_addr_nx;
    logic [XLEN-1:0]  r_wdata,    w_wdata_nx;
    logic [REG_W-1:0] r_rd_l,     w_rd_l_nx;
    logic             r_mtr_l,    w_mtr_l_nx;
    logic             r_rw_l,     w_rw_l_nx;
    logic             r_misalign, w_misalign_nx;
    logic             r_bus_err,  w_bus_err_nx;
    logic             w_stall;
    logic             w_ctr_clr;
    logic             w_ctr_en;
    logic             w_tc;
    logic             w_is_mem;
    logic             w_aligned;

    assign w_is_mem  = memtoreg_in | memwrite_in;
    assign w_aligned = (alu_result_in[1:0] == 2'b00);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_ctr_clr),
        .i_en   (w_ctr_en),
        .o_tc_c (w_tc)
    );

    // Next-state and next-register values; the MEM/WB default is a bubble.
    always_comb begin
        w_state_nx    = r_state;
        w_wb_nx       = '0;
        w_req_nx      = 1'b0;
        w_we_nx       = 1'b0;
        w_addr_nx     = '0;
        w_wdata_nx    = '0;
        w_rd_l_nx     = r_rd_l;
        w_mtr_l_nx    = r_mtr_l;
        w_rw_l_nx     = r_rw_l;
        w_misalign_nx = 1'b0;
        w_bus_err_nx  = 1'b0;
        w_stall       = 1'b0;
        w_ctr_clr     = 1'b0;
        w_ctr_en      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_is_mem) begin
                    w_wb_nx.alu_result = alu_result_in;
                    w_wb_nx.rd         = rd_in;
                    w_wb_nx.memtoreg   = memtoreg_in;
                    w_wb_nx.regwrite   = regwrite_in;
                end else if (w_aligned) begin
                    w_stall    = 1'b1;
                    w_state_nx = BUSY;
                    w_ctr_clr  = 1'b1;
                    w_req_nx   = 1'b1;
                    w_we_nx    = memwrite_in;
                    w_addr_nx  = alu_result_in;
                    w_wdata_nx = writedata_in;
                    w_rd_l_nx  = rd_in;
                    w_mtr_l_nx = memtoreg_in;
                    w_rw_l_nx  = regwrite_in;
                end else begin
                    w_misalign_nx = 1'b1;
                end
            end
            BUSY: begin
                // Ready beats the timeout when both land in the same cycle.
                if (dmem_ready) begin
                    w_state_nx         = IDLE;
                    w_wb_nx.readdata   = r_we ? '0 : dmem_rdata;
                    w_wb_nx.alu_result = r_addr;
                    w_wb_nx.rd         = r_rd_l;
                    w_wb_nx.memtoreg   = r_mtr_l;
                    w_wb_nx.regwrite   = r_rw_l;
                end else if (w_tc) begin
                    w_state_nx   = IDLE;
                    w_bus_err_nx = 1'b1;
                end else begin
                    w_stall    = 1'b1;
                    w_ctr_en   = 1'b1;
                    w_req_nx   = r_req;
                    w_we_nx    = r_we;
                    w_addr_nx  = r_addr;
                    w_wdata_nx = r_wdata;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wb       <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_l     <= '0;
            r_mtr_l    <= 1'b0;
            r_rw_l     <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wb       <= w_wb_nx;
            r_req      <= w_req_nx;
            r_we       <= w_we_nx;
            r_addr     <= w_addr_nx;
            r_wdata    <= w_wdata_nx;
            r_rd_l     <= w_rd_l_nx;
            r_mtr_l    <= w_mtr_l_nx;
            r_rw_l     <= w_rw_l_nx;
            r_misalign <= w_misalign_nx;
            r_bus_err  <= w_bus_err_nx;
        end
    end

    // Stall is forced low while reset is held so the pipeline is never frozen by a stale op.
    assign stall          = reset & w_stall;
    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign readdata_out   = r_wb.readdata;
    assign alu_result_out = r_wb.alu_result;
    assign rd_out         = r_wb.rd;
    assign memtoreg_out   = r_wb.memtoreg;
    assign regwrite_out   = r_wb.regwrite;
    assign misalign_out   = r_misalign;
    assign bus_err_out    = r_bus_err;

endmodule
